// File: rtl/ether_import_pkg.sv
// Shared types and constants for the RMII receive importer and its byte assembler.
package ether_import_pkg;

  localparam int ADDR_BITS = 12;
  localparam int BRAM_SIZE = 3072;

  localparam int         ETH_HEADER_BYTES = 14;
  localparam int         ETH_FCS_BYTES    = 4;
  localparam logic [1:0] ETH_SFD_DIBIT    = 2'b11;
  localparam logic [1:0] ETH_PRE_DIBIT    = 2'b01;

  typedef enum logic [2:0] {
    WAIT_IDLE,
    IDLE,
    PREAMBLE,
    HEADER,
    ADDR,
    PAYLOAD,
    DROP
  } ether_rx_state_t;

  // Pixel addresses carry one spare MSB so a run past the end never aliases back in range.
  function automatic logic pix_in_range(input logic [ADDR_BITS:0] a);
    return a < (ADDR_BITS + 1)'(BRAM_SIZE);
  endfunction

endpackage

// File: rtl/ether_import_if.sv
// RMII receive pins plus the BRAM pixel write port; slave is the importer side.
interface ether_import_if;
  import ether_import_pkg::*;

  logic                 eth_crsdv;
  logic [1:0]           eth_rxd;
  logic [ADDR_BITS-1:0] write_addr_out;
  logic [3:0]           write_data_out;
  logic                 write_enable_out;
  logic                 frame_done_out;
  logic                 frame_error_out;

  modport slave (
    input  eth_crsdv, eth_rxd,
    output write_addr_out, write_data_out, write_enable_out, frame_done_out, frame_error_out
  );

  modport master (
    output eth_crsdv, eth_rxd,
    input  write_addr_out, write_data_out, write_enable_out, frame_done_out, frame_error_out
  );
endinterface

// File: rtl/ether_import_rmii_byte_assembler.sv
// Packs four LSB-first RMII dibits into a byte; byte_vld_o is combinational on the 4th dibit.
// Counter and shifter clear whenever carrier drops or the caller is not in a receive state.
module rmii_byte_assembler (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       run_i,
  input  logic       crsdv_i,
  input  logic [1:0] rxd_i,
  output logic       byte_vld_o,
  output logic [7:0] byte_dat_o,
  output logic [1:0] dibit_cnt_o
);

  logic [5:0] shift_q;
  logic [1:0] cnt_q;

  always_ff @(posedge clk_in) begin
    if (rst_in || !run_i || !crsdv_i) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= {rxd_i, shift_q[5:2]};
      cnt_q   <= cnt_q + 2'd1;
    end
  end

  assign byte_vld_o  = run_i && crsdv_i && (cnt_q == 2'd3);
  assign byte_dat_o  = {rxd_i, shift_q};
  assign dibit_cnt_o = cnt_q;

endmodule

// File: rtl/ether_import.sv
// RMII frame importer: preamble/SFD hunt, EtherType filter, payload bytes -> 4-bit pixel writes.
// Low nibble written 1 cycle after a byte pops, high nibble 2 cycles after; no backpressure.
module ether_import
  import ether_import_pkg::*;
#(
  parameter logic [15:0] ETHERTYPE    = 16'h88B5,
  parameter int          MIN_PREAMBLE = 4
) (
  input logic           clk_in,
  input logic           rst_in,
  ether_import_if.slave bus
);

  localparam logic [ADDR_BITS:0] PIX_ONE = (ADDR_BITS + 1)'(1);
  localparam logic [2:0]         DL_FULL = 3'(ETH_FCS_BYTES);

  ether_rx_state_t      state_q, state_d;
  logic [4:0]           pre_cnt_q, pre_cnt_d;
  logic [3:0]           byte_cnt_q, byte_cnt_d;
  logic [7:0]           hold_q, hold_d;
  logic [ADDR_BITS:0]   pix_addr_q, pix_addr_d;
  logic [3:0][7:0]      dl_q, dl_d;
  logic [2:0]           dl_cnt_q, dl_cnt_d;
  logic                 hi_pend_q, hi_pend_d;
  logic [3:0]           hi_nib_q, hi_nib_d;
  logic [ADDR_BITS-1:0] wr_addr_q, wr_addr_d;
  logic [3:0]           wr_data_q, wr_data_d;
  logic                 wr_en_q, wr_en_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;

  logic                 rx_active;
  logic                 asm_vld;
  logic [7:0]           asm_byte;
  logic [1:0]           asm_cnt;
  logic [ADDR_BITS-1:0] addr_word;

  assign rx_active = state_q inside {HEADER, ADDR, PAYLOAD};
  assign addr_word = ADDR_BITS'({hold_q, asm_byte});

  rmii_byte_assembler u_asm (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .run_i       (rx_active),
    .crsdv_i     (bus.eth_crsdv),
    .rxd_i       (bus.eth_rxd),
    .byte_vld_o  (asm_vld),
    .byte_dat_o  (asm_byte),
    .dibit_cnt_o (asm_cnt)
  );

  always_comb begin
    state_d    = state_q;
    pre_cnt_d  = pre_cnt_q;
    byte_cnt_d = byte_cnt_q;
    hold_d     = hold_q;
    pix_addr_d = pix_addr_q;
    dl_d       = dl_q;
    dl_cnt_d   = dl_cnt_q;
    hi_pend_d  = 1'b0;
    hi_nib_d   = hi_nib_q;
    wr_addr_d  = '0;
    wr_data_d  = '0;
    wr_en_d    = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;

    // The high nibble of a popped byte always issues, even across a frame end.
    if (hi_pend_q) begin
      wr_addr_d  = pix_addr_q[ADDR_BITS-1:0];
      wr_data_d  = hi_nib_q;
      wr_en_d    = pix_in_range(pix_addr_q);
      pix_addr_d = pix_addr_q + PIX_ONE;
    end

    case (state_q)
      WAIT_IDLE: if (!bus.eth_crsdv) state_d = IDLE;
      IDLE: begin
        if (bus.eth_crsdv && bus.eth_rxd == ETH_PRE_DIBIT) begin
          state_d   = PREAMBLE;
          pre_cnt_d = 5'd1;
        end
      end
      PREAMBLE: begin
        if (!bus.eth_crsdv) begin
          state_d = DROP;
        end else if (bus.eth_rxd == ETH_PRE_DIBIT) begin
          if (pre_cnt_q != 5'd31) pre_cnt_d = pre_cnt_q + 5'd1;
        end else if (bus.eth_rxd == ETH_SFD_DIBIT && int'(pre_cnt_q) >= MIN_PREAMBLE) begin
          state_d    = HEADER;
          byte_cnt_d = '0;
        end else begin
          state_d = DROP;
        end
      end
      HEADER: begin
        if (!bus.eth_crsdv) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (asm_vld) begin
          byte_cnt_d = byte_cnt_q + 4'd1;
          if (byte_cnt_q == 4'(ETH_HEADER_BYTES - 2)) hold_d = asm_byte;
          if (byte_cnt_q == 4'(ETH_HEADER_BYTES - 1)) begin
            state_d    = ({hold_q, asm_byte} == ETHERTYPE) ? ADDR : DROP;
            byte_cnt_d = '0;
          end
        end
      end
      ADDR: begin
        if (!bus.eth_crsdv) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (asm_vld) begin
          if (byte_cnt_q == 4'd0) begin
            hold_d     = asm_byte;
            byte_cnt_d = 4'd1;
          end else begin
            pix_addr_d = {1'b0, addr_word};
            dl_cnt_d   = '0;
            state_d    = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        if (!bus.eth_crsdv) begin
          // A full delay line at a byte boundary means the held bytes are exactly the FCS.
          if (asm_cnt == 2'd0 && dl_cnt_q == DL_FULL) done_d = 1'b1;
          else                                         err_d  = 1'b1;
          dl_cnt_d = '0;
          state_d  = IDLE;
        end else if (asm_vld) begin
          if (dl_cnt_q == DL_FULL) begin
            wr_addr_d  = pix_addr_q[ADDR_BITS-1:0];
            wr_data_d  = dl_q[0][3:0];
            wr_en_d    = pix_in_range(pix_addr_q);
            hi_pend_d  = 1'b1;
            hi_nib_d   = dl_q[0][7:4];
            pix_addr_d = pix_addr_q + PIX_ONE;
            dl_d       = {asm_byte, dl_q[3:1]};
          end else begin
            dl_d[dl_cnt_q[1:0]] = asm_byte;
            dl_cnt_d            = dl_cnt_q + 3'd1;
          end
        end
      end
      DROP:    if (!bus.eth_crsdv) state_d = IDLE;
      default: state_d = WAIT_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= WAIT_IDLE;
      pre_cnt_q  <= '0;
      byte_cnt_q <= '0;
      hold_q     <= '0;
      pix_addr_q <= '0;
      dl_q       <= '0;
      dl_cnt_q   <= '0;
      hi_pend_q  <= 1'b0;
      hi_nib_q   <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      wr_en_q    <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pre_cnt_q  <= pre_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      hold_q     <= hold_d;
      pix_addr_q <= pix_addr_d;
      dl_q       <= dl_d;
      dl_cnt_q   <= dl_cnt_d;
      hi_pend_q  <= hi_pend_d;
      hi_nib_q   <= hi_nib_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      wr_en_q    <= wr_en_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign bus.write_addr_out   = wr_addr_q;
  assign bus.write_data_out   = wr_data_q;
  assign bus.write_enable_out = wr_en_q;
  assign bus.frame_done_out   = done_q;
  assign bus.frame_error_out  = err_q;

endmodule

// File: tb/tb_ether_import.sv
// Scenario bench for ether_import: expected pixel writes queued as frames are driven.
module tb_ether_import;
  import ether_import_pkg::*;

  typedef logic [ADDR_BITS+3:0] wr_t;

  logic clk_in = 1'b0;
  logic rst_in;
  always #10 clk_in = ~clk_in;

  ether_import_if bus ();

  ether_import #(.ETHERTYPE(16'h88B5), .MIN_PREAMBLE(4)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  wr_t        exp_q[$];
  logic [7:0] body_q[$];
  int checks   = 0;
  int passed   = 0;
  int done_cnt = 0;
  int err_cnt  = 0;

  // Every observed write is matched against the oldest expected pixel.
  always @(negedge clk_in) begin
    if (bus.frame_done_out === 1'b1)  done_cnt++;
    if (bus.frame_error_out === 1'b1) err_cnt++;
    if (bus.write_enable_out === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL pixel_write: unexpected write addr=%h data=%h, required none",
                 bus.write_addr_out, bus.write_data_out);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if ({bus.write_addr_out, bus.write_data_out} !== e)
          $display("FAIL pixel_write: got addr=%h data=%h, required addr=%h data=%h",
                   bus.write_addr_out, bus.write_data_out, e[ADDR_BITS+3:4], e[3:0]);
        else
          passed++;
      end
    end
  end

  task automatic send_dibit(input logic [1:0] d, input logic crs);
    @(posedge clk_in);
    #1;
    bus.eth_crsdv = crs;
    bus.eth_rxd   = d;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 0; i < 4; i++) send_dibit(b[2*i +: 2], 1'b1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send_dibit(2'b00, 1'b0);
  endtask

  task automatic expect_pixel(input int a, input logic [3:0] nib);
    if (a < BRAM_SIZE) exp_q.push_back({ADDR_BITS'(a), nib});
  endtask

  // Drives preamble, header, address, body_q and extra dibits; carrier stays high afterwards.
  task automatic send_frame(input int n_pre, input logic [15:0] etype, input logic [15:0] addr,
                            input int extra, input bit accept);
    int base;
    base = int'(addr) % (1 << ADDR_BITS);
    if (accept) begin
      for (int i = 0; i < body_q.size() - ETH_FCS_BYTES; i++) begin
        expect_pixel(base + 2*i,     body_q[i][3:0]);
        expect_pixel(base + 2*i + 1, body_q[i][7:4]);
      end
    end
    for (int i = 0; i < n_pre; i++) send_dibit(2'b01, 1'b1);
    send_dibit(ETH_SFD_DIBIT, 1'b1);
    for (int i = 0; i < 6; i++) send_byte(8'hFF);
    for (int i = 0; i < 6; i++) send_byte(8'(8'h10 + i));
    send_byte(etype[15:8]);
    send_byte(etype[7:0]);
    send_byte(addr[15:8]);
    send_byte(addr[7:0]);
    for (int i = 0; i < body_q.size(); i++) send_byte(body_q[i]);
    for (int i = 0; i < extra; i++) send_dibit(2'b10, 1'b1);
  endtask

  task automatic check_end(input string name, input int d0, input int e0,
                           input int dexp, input int eexp);
    checks++;
    if (exp_q.size() != 0) $display("FAIL %s_drain: pending writes=%0d, required 0", name, exp_q.size());
    else passed++;
    checks++;
    if (done_cnt - d0 != dexp) $display("FAIL %s_done: pulses=%0d, required %0d", name, done_cnt - d0, dexp);
    else passed++;
    checks++;
    if (err_cnt - e0 != eexp) $display("FAIL %s_error: pulses=%0d, required %0d", name, err_cnt - e0, eexp);
    else passed++;
  endtask

  task automatic test_reset();
    rst_in        = 1'b1;
    bus.eth_crsdv = 1'b0;
    bus.eth_rxd   = 2'b00;
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    checks++;
    if (bus.write_enable_out !== 1'b0) $display("FAIL reset_we: got %b, required 0", bus.write_enable_out);
    else passed++;
    checks++;
    if (bus.write_addr_out !== '0) $display("FAIL reset_addr: got %h, required 0", bus.write_addr_out);
    else passed++;
    checks++;
    if (bus.write_data_out !== 4'h0) $display("FAIL reset_data: got %h, required 0", bus.write_data_out);
    else passed++;
    checks++;
    if (bus.frame_done_out !== 1'b0) $display("FAIL reset_done: got %b, required 0", bus.frame_done_out);
    else passed++;
    checks++;
    if (bus.frame_error_out !== 1'b0) $display("FAIL reset_error: got %b, required 0", bus.frame_error_out);
    else passed++;
    @(posedge clk_in);
    #1 rst_in = 1'b0;
    idle(2);
  endtask

  task automatic test_clean_frame();
    int d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    body_q = '{8'h21, 8'h43, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    send_frame(31, 16'h88B5, 16'h0010, 0, 1'b1);
    send_dibit(2'b00, 1'b0);
    @(posedge clk_in);
    @(negedge clk_in);
    checks++;
    if (bus.frame_done_out !== 1'b1) $display("FAIL clean_done_timing: got %b, required 1", bus.frame_done_out);
    else passed++;
    idle(8);
    check_end("clean", d0, e0, 1, 0);
  endtask

  task automatic test_followup_frame(input string name);
    int d0, e0, n;
    logic [15:0] addr;
    d0 = done_cnt; e0 = err_cnt;
    body_q.delete();
    n = $urandom_range(2, 5);
    for (int i = 0; i < n + ETH_FCS_BYTES; i++) body_q.push_back(8'($urandom));
    addr = 16'($urandom_range(0, 3000));
    send_frame(31, 16'h88B5, addr, 0, 1'b1);
    send_dibit(2'b00, 1'b0);
    @(posedge clk_in);
    @(negedge clk_in);
    checks++;
    if (bus.frame_done_out !== 1'b1) $display("FAIL %s_done_timing: got %b, required 1", name, bus.frame_done_out);
    else passed++;
    idle(6);
    check_end(name, d0, e0, 1, 0);
  endtask

  task automatic test_wrong_type();
    int d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    body_q = '{8'h21, 8'h43, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    send_frame(31, 16'h0800, 16'h0010, 0, 1'b0);
    idle(8);
    check_end("wrong_type", d0, e0, 0, 0);
  endtask

  task automatic test_truncated();
    int d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    body_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    send_frame(31, 16'h88B5, 16'h0020, 1, 1'b1);
    idle(8);
    check_end("truncated", d0, e0, 0, 1);
  endtask

  task automatic test_addr_bound();
    int d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    body_q = '{8'hBA, 8'h01, 8'h02, 8'h03, 8'h04};
    send_frame(31, 16'h88B5, 16'(BRAM_SIZE - 1), 0, 1'b1);
    idle(8);
    check_end("addr_bound", d0, e0, 1, 0);
  endtask

  task automatic test_reset_mid();
    int d0, e0;
    body_q = '{8'h01, 8'h02, 8'h03};
    send_frame(31, 16'h88B5, 16'h0040, 0, 1'b0);
    rst_in = 1'b1;
    send_dibit(2'b01, 1'b1);
    rst_in = 1'b0;
    d0 = done_cnt; e0 = err_cnt;
    @(negedge clk_in);
    checks++;
    if (bus.write_enable_out !== 1'b0) $display("FAIL reset_mid_we: got %b, required 0", bus.write_enable_out);
    else passed++;
    for (int i = 0; i < 99; i++) send_dibit(2'($urandom_range(0, 3)), 1'b1);
    idle(4);
    check_end("reset_mid", d0, e0, 0, 0);
  endtask

  task automatic test_short_preamble();
    int d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    body_q = '{8'h77, 8'h88, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    send_frame(2, 16'h88B5, 16'h0050, 0, 1'b0);
    idle(6);
    check_end("short_preamble", d0, e0, 0, 0);
  endtask

  task automatic test_back_to_back();
    int d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    for (int f = 0; f < 2; f++) begin
      body_q.delete();
      for (int i = 0; i < 3 + 3*f + ETH_FCS_BYTES; i++) body_q.push_back(8'($urandom));
      send_frame(31, 16'h88B5, 16'($urandom), 0, 1'b1);
      send_dibit(2'b00, 1'b0);
    end
    idle(6);
    check_end("back_to_back", d0, e0, 2, 0);
  endtask

  initial begin
    test_reset();
    test_clean_frame();
    test_wrong_type();
    test_followup_frame("after_wrong_type");
    test_truncated();
    test_followup_frame("after_truncated");
    test_addr_bound();
    test_reset_mid();
    test_followup_frame("after_reset");
    test_short_preamble();
    test_followup_frame("after_short_preamble");
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/ether_import.md
# ether_import

RMII receive-side frame importer, the inverse of `ether_export`. It deserializes 2-bit RMII dibits from the PHY, finds preamble/SFD, and filters on EtherType. It unpacks payload bytes into 4-bit pixels and writes them into the frame BRAM through `bram_manager`'s write port, starting at an address carried in the frame. The 4-byte FCS is held back in a delay line and never written; CRC is not checked.

## Interface

- `ETHERTYPE`, default `16'h88B5`: accepted EtherType; frames with any other value are dropped.
- `MIN_PREAMBLE`, default `4`: minimum count of `2'b01` dibits before the SFD dibit `2'b11` is accepted.

- `clk_in`  in  1  50 MHz RMII reference clock; all logic is in this domain.
- `rst_in`  in  1  synchronous, active-high reset.
- `eth_crsdv`  in  1  RMII carrier-sense/data-valid.
- `eth_rxd`  in  2  RMII receive dibit, LSB-first within each byte.
- `write_addr_out`  out  `ADDR_BITS`  BRAM pixel address.
- `write_data_out`  out  4  pixel value.
- `write_enable_out`  out  1  one-cycle write strobe.
- `frame_done_out`  out  1  one-cycle pulse when a frame ends cleanly.
- `frame_error_out`  out  1  one-cycle pulse when a frame is aborted or malformed.

## Operation

- All outputs reset to 0. State resets to `WAIT_IDLE`, and the delay line is marked empty.
- States:
  - `WAIT_IDLE`: stay while `eth_crsdv`=1; go to `IDLE` on `eth_crsdv`=0. This prevents locking onto a frame already in progress after reset.
  - `IDLE`: on `eth_crsdv`=1 with `eth_rxd`=01, go to `PREAMBLE` with the preamble count set to 1.
  - `PREAMBLE`:
    - 01: count++, saturating at 31.
    - 11 with count ≥ `MIN_PREAMBLE`: go to `HEADER`.
    - Any other dibit, or `eth_crsdv`=0: go to `DROP`.
  - `HEADER`: assemble 14 bytes (dst 6, src 6, type 2). The type is big-endian.
    - Mismatch: go to `DROP`, no error pulse.
    - Match: go to `ADDR`.
  - `ADDR`: 2 bytes, big-endian start pixel address; take the low `ADDR_BITS` bits as the base. Then go to `PAYLOAD`.
  - `PAYLOAD`: each completed byte is pushed into a 4-entry byte FIFO/delay line. When a push finds 4 valid entries, the oldest byte is popped and emitted as two pixels:
    - low nibble at address A;
    - high nibble at A+1;
    - A then advances by 2.
  - `DROP`: ignore input until `eth_crsdv`=0, then go to `IDLE`.
- Byte assembly: the shift register takes the dibit into bits [7:6] and shifts right. The byte completes on the 4th dibit, when the dibit counter wraps 3→0.
- Frame end (`eth_crsdv`=0 while in `HEADER`/`ADDR`/`PAYLOAD`):
  - Clean end (dibit counter = 0, and at least 4 payload bytes after `ADDR`): the 4 held bytes are the FCS and are discarded. `frame_done_out` pulses; go to `IDLE`.
  - Otherwise (partial byte, or fewer than 4 payload bytes): `frame_error_out` pulses; go to `IDLE`.
  - End in `HEADER`/`ADDR`: always `frame_error_out`.
  - The delay line is cleared on every frame end.
- Address bounds: any pixel with address ≥ `BRAM_SIZE` is suppressed (`write_enable_out`=0) but still advances A. The address register is `ADDR_BITS`+1 wide so it cannot wrap into a valid region.
- A pulse on `frame_done_out` and one on `frame_error_out` never occur in the same cycle.
- `rst_in` mid-frame: outputs go to 0 on the next edge, pending pixels are lost, and the block goes to `WAIT_IDLE`.

## Timing

- Byte N completes on cycle t. If it causes a pop:
  - low-nibble write is visible at t+1;
  - high-nibble write is visible at t+2.
- Writes are therefore ≤2 per 4 cycles and never back-to-back across bytes.
- The last popped byte's high-nibble write at t+2 may coincide with `eth_crsdv` falling. It is still issued, and `frame_done_out` is asserted in the cycle after `eth_crsdv` is first sampled 0. The pending write is never cancelled.
- Registered outputs only; no combinational path from `eth_rxd` to any output.
- BRAM write latency is owned by `bram_manager`. The importer holds each address/data/enable triple for exactly one cycle.

## Structure

- `ADDR_BITS` and `BRAM_SIZE` come from `types.svh`. Add to the shared package:
  - the state enum `ether_rx_state_t`;
  - `ETH_HEADER_BYTES`=14;
  - `ETH_FCS_BYTES`=4;
  - `ETH_SFD_DIBIT`=2'b11.
- One sub-module is natural: `rmii_byte_assembler`, which handles dibit shift, counter, and a `byte_valid` pulse, and clears on `eth_crsdv`=0. The FSM, delay line and pixel emitter stay in `ether_import`.

## Test plan

- Reset then a clean frame: 7×0x55 + 0xD5 preamble/SFD, type 0x88B5, addr 0x0010, payload 0x21 0x43, 4 FCS bytes. Expect:
  - writes (0x10,1), (0x11,2), (0x12,3), (0x13,4) and no others;
  - `frame_done_out` exactly once.
- Same frame with type 0x0800: no writes and no pulses; the next valid frame is accepted.
- Frame truncated 1 dibit into a payload byte: `frame_error_out`=1 for one cycle; the block accepts the next frame.
- Addr = `BRAM_SIZE`-1 with payload 0xBA: write (`BRAM_SIZE`-1, 0xA) only; the high nibble is suppressed; `frame_done_out` still pulses.
- `rst_in` asserted mid-payload with `eth_crsdv` held high for 100 more cycles: no writes. After `eth_crsdv` drops, a fresh frame imports correctly.
- Preamble with only 2 dibits of 01 before 11: no writes and no `frame_done_out`; frame dropped.
